conv_feature_writer: RTL and testbench

Output-side interface of the convolution layer: accepts rows of ARRAY_SIZE IEEE-754 single-precision results from the convolution kernel array and serializes them into a feature-map RAM write port, one word per cycle. It is the write-direction counterpart of the layer's input interface, which reads ROM words and assembles them into a multi-word pixel bus. The layer controller drives it with the same 2-bit cmd/ack scheme it uses for the input interface. It buffers two rows, so the kernel array can deliver a new row while the previous one drains.

---
 rtl/conv_layer_pkg.sv | 31 +++
 rtl/conv_row_buffer.sv | 69 ++++++
 rtl/conv_feature_writer.sv | 189 ++++++++++++++++++
 tb/tb_conv_feature_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_pkg.sv
// Shared types and defaults for the convolution layer blocks.
// Contents: controller cmd/ack encodings, writer FSM state encoding and
// default geometry (word width, kernel array width, output rows per frame).
package conv_layer_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ARRAY_SIZE_DEF = 6;
  localparam int unsigned OUT_ROWS_DEF   = 6;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_START   = 2'b01,
    CMD_STOP    = 2'b10,
    CMD_NOP_ALT = 2'b11
  } conv_cmd_e;

  typedef enum logic [1:0] {
    ACK_IDLE = 2'b00,
    ACK_BUSY = 2'b01,
    ACK_DONE = 2'b10,
    ACK_RSVD = 2'b11
  } conv_ack_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_DONE   = 3'd3
  } conv_state_e;

endpackage

// File: rtl/conv_row_buffer.sv
// Two-entry ping-pong row store between the kernel array and the RAM drain.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             empty the buffer (pointers and occupancy to 0)
//   push, push_data write one row into the free slot
//   pop             release the oldest row
//   rd_data         oldest row (valid while occupancy != 0)
//   occupancy       rows held, 0..2
module conv_row_buffer
  import conv_layer_pkg::*;
#(
  parameter int unsigned ROW_WIDTH = DATA_WIDTH_DEF * ARRAY_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 push,
  input  logic [ROW_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic [ROW_WIDTH-1:0] rd_data,
  output logic [1:0]           occupancy
);

  logic [ROW_WIDTH-1:0] mem_q [2];
  logic [ROW_WIDTH-1:0] mem_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           occ_q, occ_d;

  // Next-state for storage, pointers and occupancy; clear wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clr) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      occ_d = occ_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rd_data   = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/conv_feature_writer.sv
// Serializes rows of ARRAY_SIZE words from the kernel array into a feature-map
// RAM write port, one word per cycle, under the controller's cmd/ack protocol.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   enable             run enable; low freezes the block
//   cmd / ack          controller command in, status out (busy / frame done)
//   feat_valid/ready   row handshake (feat_ready is combinational)
//   feature            row, element 0 in the most significant slice
//   ram_we/addr/data   RAM write port
//   current_state      FSM state encoding
//   done               1-cycle pulse after the last word of the frame
// Optional: CONV_OUT_RELU_EN clamps words with the sign bit set to zero.
module conv_feature_writer
  import conv_layer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int unsigned OUT_ROWS   = OUT_ROWS_DEF,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [1:0]                     cmd,
  output logic [1:0]                     ack,
  input  logic                           feat_valid,
  output logic                           feat_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] feature,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0]          ram_data,
  output logic [2:0]                     current_state,
  output logic                           done
);

  localparam int unsigned ROW_WIDTH = ARRAY_SIZE * DATA_WIDTH;
  localparam int unsigned ROW_CW    = $clog2(OUT_ROWS + 1);
  localparam int unsigned COL_CW    = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  conv_state_e           state_q, state_d;
  logic [ROW_CW-1:0]     row_cnt_q, row_cnt_d;   // rows fully written
  logic [COL_CW-1:0]     col_cnt_q, col_cnt_d;   // next word within the row
  logic [ROW_CW-1:0]     acc_cnt_q, acc_cnt_d;   // rows accepted this frame
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic [1:0]            ack_q, ack_d;
  logic                  done_q, done_d;

  logic                  buf_clr, buf_push, buf_pop;
  logic [ROW_WIDTH-1:0]  buf_rd_data;
  logic [1:0]            buf_occ;
  logic                  accept;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] word_out;

  conv_row_buffer #(.ROW_WIDTH(ROW_WIDTH)) u_row_buffer (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .push      (buf_push),
    .push_data (feature),
    .pop       (buf_pop),
    .rd_data   (buf_rd_data),
    .occupancy (buf_occ)
  );

  assign feat_ready = enable && (state_q == ST_ACTIVE) && (buf_occ < 2'd2)
                      && (acc_cnt_q < ROW_CW'(OUT_ROWS));
  assign accept     = feat_valid && feat_ready;

  // Word selection from the oldest row, with the optional sign clamp.
  always_comb begin
    word = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (col_cnt_q == COL_CW'(i)) word = buf_rd_data[(ARRAY_SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH];
    end
`ifdef CONV_OUT_RELU_EN
    word_out = word[DATA_WIDTH-1] ? '0 : word;
`else
    word_out = word;
`endif
  end

  // FSM next state, counters, buffer control and registered write port.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    done_d     = 1'b0;
    buf_clr    = 1'b0;
    buf_push   = 1'b0;
    buf_pop    = 1'b0;

    if (enable) begin
      if (cmd == CMD_STOP) begin
        // STOP beats a simultaneous accept: the offered row is dropped.
        state_d   = ST_IDLE;
        buf_clr   = 1'b1;
        row_cnt_d = '0;
        col_cnt_d = '0;
        acc_cnt_d = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd == CMD_START) begin
              state_d   = ST_ACTIVE;
              buf_clr   = 1'b1;
              row_cnt_d = '0;
              col_cnt_d = '0;
              acc_cnt_d = '0;
            end
          end
          ST_ACTIVE, ST_FLUSH: begin
            buf_push  = accept;
            acc_cnt_d = acc_cnt_q + ROW_CW'(accept);
            if (buf_occ != 2'd0) begin
              ram_we_d   = 1'b1;
              ram_addr_d = ADDR_WIDTH'(BASE_ADDR)
                         + ADDR_WIDTH'(row_cnt_q) * ADDR_WIDTH'(ARRAY_SIZE)
                         + ADDR_WIDTH'(col_cnt_q);
              ram_data_d = word_out;
              if (col_cnt_q == COL_CW'(ARRAY_SIZE - 1)) begin
                col_cnt_d = '0;
                row_cnt_d = row_cnt_q + ROW_CW'(1);
                buf_pop   = 1'b1;
              end else begin
                col_cnt_d = col_cnt_q + COL_CW'(1);
              end
            end
            if (state_q == ST_ACTIVE && acc_cnt_d == ROW_CW'(OUT_ROWS)) begin
              state_d = ST_FLUSH;
            end
            // Entered one edge after the final write has been issued.
            if (state_q == ST_FLUSH && buf_occ == 2'd0 && row_cnt_q == ROW_CW'(OUT_ROWS)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
          ST_DONE: state_d = ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end

    case (state_d)
      ST_ACTIVE, ST_FLUSH: ack_d = ACK_BUSY;
      ST_DONE:             ack_d = ACK_DONE;
      default:             ack_d = ACK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      acc_cnt_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= ADDR_WIDTH'(BASE_ADDR);
      ram_data_q <= '0;
      ack_q      <= ACK_IDLE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
    end
  end

  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_data      = ram_data_q;
  assign ack           = ack_q;
  assign done          = done_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_conv_feature_writer.sv
// Directed bench for conv_feature_writer: full frames, gaps, backpressure,
// enable pause, STOP, ReLU row and asynchronous reset.
module tb_conv_feature_writer;

  localparam int unsigned DW = 32;
  localparam int unsigned AS = 6;
  localparam int unsigned AW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [1:0]         cmd;
  logic [1:0]         ack;
  logic               feat_valid;
  logic               feat_ready;
  logic [AS*DW-1:0]   feature;
  logic               ram_we;
  logic [AW-1:0]      ram_addr;
  logic [DW-1:0]      ram_data;
  logic [2:0]         current_state;
  logic               done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [1:0] done_ack = 2'b00;
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int            wc[$];

  conv_feature_writer dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .cmd           (cmd),
    .ack           (ack),
    .feat_valid    (feat_valid),
    .feat_ready    (feat_ready),
    .feature       (feature),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_data      (ram_data),
    .current_state (current_state),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and done monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (ram_we) begin
      wa.push_back(ram_addr);
      wd.push_back(ram_data);
      wc.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      done_ack = ack;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [AS*DW-1:0] mk_row(input logic [31:0] base);
    logic [AS*DW-1:0] r;
    for (int i = 0; i < AS; i++) r[(AS-1-i)*DW +: DW] = base + 32'(i);
    return r;
  endfunction

  function automatic logic [31:0] relu_exp(input logic [31:0] x);
`ifdef CONV_OUT_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  // Offer a row and wait (bounded) until it is taken at a clock edge.
  task automatic send_row(input logic [AS*DW-1:0] row, output int waited);
    int n = 0;
    feature    = row;
    feat_valid = 1'b1;
    while (!feat_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("row_accept_timeout", 32'(n < 50), 32'd1);
    @(negedge clk);
    feat_valid = 1'b0;
    waited = n;
  endtask

  task automatic start_frame();
    cmd = 2'b01;
    @(negedge clk);
    cmd = 2'b00;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 32'(n < 200), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input int b, input string tag);
    check({tag, "_nwrites"}, 32'(wa.size() - b), 32'd36);
    for (int i = 0; i < 36 && b + i < wa.size(); i++) begin
      check({tag, "_addr"}, 32'(wa[b+i]), 32'(i));
      check({tag, "_data"}, wd[b+i], 32'h3F80_0000 + 32'(i));
    end
  endtask

  initial begin
    int w;
    int b;
    int n;
    int max_w;
    int d0;
    logic [31:0] rv [6];
    logic [AS*DW-1:0] rrow;

    rst = 1'b1; enable = 1'b1; cmd = 2'b00; feat_valid = 1'b0; feature = '0;
    #12;
    check("rst_we",    32'(ram_we), 32'd0);
    check("rst_addr",  32'(ram_addr), 32'd0);
    check("rst_data",  ram_data, 32'd0);
    check("rst_ack",   32'(ack), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ready", 32'(feat_ready), 32'd0);
    check("rst_state", 32'(current_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Frame A: six back-to-back rows.
    start_frame();
    check("a_state_active", 32'(current_state), 32'd1);
    check("a_ack_busy", 32'(ack), 32'd1);
    b = wa.size();
    d0 = done_cnt;
    for (int r = 0; r < 6; r++) send_row(mk_row(32'h3F80_0000 + 32'(r * 6)), w);
    wait_done(d0);
    check_frame(b, "a");
    if (wa.size() - b == 36) begin
      check("a_no_gaps", 32'(wc[b+35] - wc[b]), 32'd35);
      check("a_done_lat", 32'(done_cyc - wc[b+35]), 32'd1);
    end
    check("a_done_count", 32'(done_cnt - d0), 32'd1);
    check("a_done_ack", 32'(done_ack), 32'd2);
    check("a_idle_after", 32'(current_state), 32'd0);
    check("a_ack_idle", 32'(ack), 32'd0);

    // Frame B: gap after row 0, enable pause in row 1, held valid for rows 2..5.
    start_frame();
    b = wa.size();
    d0 = done_cnt;
    send_row(mk_row(32'h3F80_0000), w);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("b_ready_gap", 32'(feat_ready), 32'd1);
    end
    check("b_gap_writes", 32'(wa.size() - b), 32'd6);
    check("b_gap_we_low", 32'(ram_we), 32'd0);

    send_row(mk_row(32'h3F80_0006), w);
    n = 0;
    while (!(ram_we && ram_addr == 8'd8) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b_word2_timeout", 32'(n < 20), 32'd1);
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b_pause_we", 32'(ram_we), 32'd0);
    end
    enable = 1'b1;
    @(negedge clk);
    check("b_resume_we", 32'(ram_we), 32'd1);
    check("b_resume_addr", 32'(ram_addr), 32'd9);
    check("b_resume_data", ram_data, 32'h3F80_0009);

    max_w = 0;
    for (int r = 2; r < 6; r++) begin
      send_row(mk_row(32'h3F80_0000 + 32'(r * 6)), w);
      if (w > max_w) max_w = w;
    end
    check("b_ready_dropped", 32'(max_w > 0), 32'd1);
    wait_done(d0);
    check_frame(b, "b");

    // Frame C: STOP on the same edge as an offered row.
    start_frame();
    send_row(mk_row(32'h4000_0000), w);
    send_row(mk_row(32'h4000_0006), w);
    feature    = mk_row(32'h4000_000C);
    feat_valid = 1'b1;
    n = 0;
    while (!feat_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("c_ready_timeout", 32'(n < 50), 32'd1);
    cmd = 2'b10;
    @(negedge clk);
    cmd = 2'b00;
    feat_valid = 1'b0;
    check("c_stop_we", 32'(ram_we), 32'd0);
    check("c_stop_state", 32'(current_state), 32'd0);
    check("c_stop_ack", 32'(ack), 32'd0);
    check("c_stop_ready", 32'(feat_ready), 32'd0);
    b = wa.size();
    repeat (5) @(negedge clk);
    check("c_no_writes", 32'(wa.size() - b), 32'd0);

    // Restart with a sign-bit row; writes start again at address 0.
    rv = '{32'hBF80_0000, 32'h8000_0000, 32'h3F80_0000,
           32'hFFC0_0000, 32'h7F80_0000, 32'h0000_0001};
    for (int i = 0; i < AS; i++) rrow[(AS-1-i)*DW +: DW] = rv[i];
    start_frame();
    b = wa.size();
    send_row(rrow, w);
    repeat (8) @(negedge clk);
    check("d_nwrites", 32'(wa.size() - b), 32'd6);
    for (int i = 0; i < 6 && b + i < wa.size(); i++) begin
      check("d_addr", 32'(wa[b+i]), 32'(i));
      check("d_data", wd[b+i], relu_exp(rv[i]));
    end

    // Asynchronous reset in the middle of a row drain.
    send_row(mk_row(32'h5000_0000), w);
    @(negedge clk);
    @(negedge clk);
    check("e_pre_we", 32'(ram_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("e_rst_we", 32'(ram_we), 32'd0);
    check("e_rst_addr", 32'(ram_addr), 32'd0);
    check("e_rst_data", ram_data, 32'd0);
    check("e_rst_state", 32'(current_state), 32'd0);
    check("e_rst_ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
